// File: rtl/hsv_pkg.sv
// Shared definitions for the HSV colour-detect path: function codes,
// pixel formats and the channel field offsets of each format.
package hsv_pkg;
    typedef enum logic [1:0] {
        HSV_ACHROM = 2'd0,
        HSV_RED    = 2'd1,
        HSV_GRN    = 2'd2,
        HSV_BLU    = 2'd3
    } hsv_func_e;

    localparam int FMT_RGB565 = 0;
    localparam int FMT_RGB888 = 1;

    localparam int RGB565_R_LSB = 0;
    localparam int RGB565_R_W   = 5;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_G_W   = 6;
    localparam int RGB565_B_LSB = 11;
    localparam int RGB565_B_W   = 5;

    localparam int RGB888_R_LSB = 0;
    localparam int RGB888_G_LSB = 8;
    localparam int RGB888_B_LSB = 16;
    localparam int RGB888_CH_W  = 8;
endpackage

// File: rtl/rgb_unpack.sv
// Combinational pixel unpack: splits a packed RGB565/RGB888 word into three
// channels left-aligned to CH_W bits with zero fill.
module rgb_unpack
    import hsv_pkg::*;
#(
    parameter int CH_W    = 8,
    parameter int IN_MODE = FMT_RGB565
) (
    input  logic [23:0]     i_data,
    output logic [CH_W-1:0] o_red,
    output logic [CH_W-1:0] o_green,
    output logic [CH_W-1:0] o_blue
);
    generate
        if (IN_MODE == FMT_RGB888) begin : g_888
            assign o_red   = CH_W'(i_data[RGB888_R_LSB +: RGB888_CH_W]) << (CH_W - RGB888_CH_W);
            assign o_green = CH_W'(i_data[RGB888_G_LSB +: RGB888_CH_W]) << (CH_W - RGB888_CH_W);
            assign o_blue  = CH_W'(i_data[RGB888_B_LSB +: RGB888_CH_W]) << (CH_W - RGB888_CH_W);
        end else begin : g_565
            // The top byte carries nothing in 565 mode.
            logic unused_hi;
            assign unused_hi = ^i_data[23:16];
            assign o_red   = CH_W'(i_data[RGB565_R_LSB +: RGB565_R_W]) << (CH_W - RGB565_R_W);
            assign o_green = CH_W'(i_data[RGB565_G_LSB +: RGB565_G_W]) << (CH_W - RGB565_G_W);
            assign o_blue  = CH_W'(i_data[RGB565_B_LSB +: RGB565_B_W]) << (CH_W - RGB565_B_W);
        end
    endgenerate
endmodule

// File: rtl/hsv_prep_stream.sv
// Three-stage streaming HSV front end: unpack, max/min compare, then value,
// delta, signed hue dividend and sector code, with per-stage valid/ready.
module hsv_prep_stream
    import hsv_pkg::*;
#(
    parameter int CH_W    = 8,
    parameter int IN_MODE = FMT_RGB565,
    parameter int USER_W  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [23:0]            i_data,
    input  logic [USER_W-1:0]      i_user,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [CH_W-1:0]        o_value,
    output logic [CH_W-1:0]        o_delta,
    output logic signed [CH_W:0]   o_dividend,
    output logic [1:0]             o_function,
    output logic [USER_W-1:0]      o_user,
    output logic                   o_valid,
    input  logic                   i_ready
);
    function automatic logic signed [CH_W:0] sdiff(input logic [CH_W-1:0] a,
                                                   input logic [CH_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    logic ready1, ready2, ready3;
    logic v1_q, v2_q, v3_q;

    logic [CH_W-1:0]   red_d, grn_d, blu_d;
    logic [CH_W-1:0]   r1_q, g1_q, b1_q;
    logic [USER_W-1:0] user1_q;

    logic [CH_W-1:0]   max2_d, min2_d;
    hsv_func_e         sel2_d;
    logic [CH_W-1:0]   r2_q, g2_q, b2_q, max2_q, min2_q;
    hsv_func_e         sel2_q;
    logic [USER_W-1:0] user2_q;

    logic [CH_W-1:0]     delta3_d;
    logic signed [CH_W:0] div3_d;
    hsv_func_e           func3_d;
    logic [CH_W-1:0]     value_q, delta_q;
    logic signed [CH_W:0] div_q;
    hsv_func_e           func_q;
    logic [USER_W-1:0]   user_q;

    // An empty stage always loads, so bubbles collapse toward the output.
    assign ready3  = ~v3_q | i_ready;
    assign ready2  = ~v2_q | ready3;
    assign ready1  = ~v1_q | ready2;
    assign o_ready = ready1 | i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (ready1) v1_q <= i_valid;
            if (ready2) v2_q <= v1_q;
            if (ready3) v3_q <= v2_q;
        end
    end

    // S1: unpack and expand
    rgb_unpack #(.CH_W(CH_W), .IN_MODE(IN_MODE)) u_unpack (
        .i_data  (i_data),
        .o_red   (red_d),
        .o_green (grn_d),
        .o_blue  (blu_d)
    );

    always_ff @(posedge i_clk) begin
        if (ready1 && i_valid) begin
            r1_q    <= red_d;
            g1_q    <= grn_d;
            b1_q    <= blu_d;
            user1_q <= i_user;
        end
    end

    // S2: compare, ties resolve red > green > blue
    always_comb begin
        sel2_d = HSV_BLU;
        max2_d = b1_q;
        if (r1_q >= g1_q && r1_q >= b1_q) begin
            sel2_d = HSV_RED;
            max2_d = r1_q;
        end else if (g1_q >= b1_q) begin
            sel2_d = HSV_GRN;
            max2_d = g1_q;
        end
        min2_d = r1_q;
        if (g1_q < min2_d) min2_d = g1_q;
        if (b1_q < min2_d) min2_d = b1_q;
    end

    always_ff @(posedge i_clk) begin
        if (ready2 && v1_q) begin
            r2_q    <= r1_q;
            g2_q    <= g1_q;
            b2_q    <= b1_q;
            max2_q  <= max2_d;
            min2_q  <= min2_d;
            sel2_q  <= sel2_d;
            user2_q <= user1_q;
        end
    end

    // S3: subtract
    always_comb begin
        delta3_d = max2_q - min2_q;
        func3_d  = sel2_q;
        case (sel2_q)
            HSV_RED: div3_d = sdiff(g2_q, b2_q);
            HSV_GRN: div3_d = sdiff(b2_q, r2_q);
            default: div3_d = sdiff(r2_q, g2_q);
        endcase
        if (delta3_d == '0) begin
            func3_d = HSV_ACHROM;
            div3_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value_q <= '0;
            delta_q <= '0;
            div_q   <= '0;
            func_q  <= HSV_ACHROM;
            user_q  <= '0;
        end else if (ready3 && v2_q) begin
            value_q <= max2_q;
            delta_q <= delta3_d;
            div_q   <= div3_d;
            func_q  <= func3_d;
            user_q  <= user2_q;
        end
    end

    assign o_value    = value_q;
    assign o_delta    = delta_q;
    assign o_dividend = div_q;
    assign o_function = func_q;
    assign o_user     = user_q;
    assign o_valid    = v3_q;
endmodule

// File: tb/tb_hsv_prep_stream.sv
// Bench for hsv_prep_stream: three configurations share one stimulus stream
// and are checked against an arithmetic reference model and a beat queue.
module tb_hsv_prep_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_valid, i_ready;
    logic [23:0] i_data;
    logic [7:0]  i_user;

    logic              o_ready0, o_ready1, o_ready2;
    logic              o_valid0, o_valid1, o_valid2;
    logic [7:0]        o_val0, o_dl0, o_val1, o_dl1;
    logic [9:0]        o_val2, o_dl2;
    logic signed [8:0] o_div0, o_div1;
    logic signed [10:0] o_div2;
    logic [1:0]        o_fn0, o_fn1, o_fn2;
    logic [7:0]        o_user0, o_user1, o_user2;

    int total = 0;
    int bad   = 0;

    typedef struct packed { int v; int dl; int dv; int f; } exp_t;
    typedef struct packed { logic [23:0] d; logic [7:0] u; } beat_t;
    beat_t sb[$];

    hsv_prep_stream #(.CH_W(8), .IN_MODE(0), .USER_W(8)) u0 (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_user(i_user), .i_valid(i_valid),
        .o_ready(o_ready0), .o_value(o_val0), .o_delta(o_dl0), .o_dividend(o_div0),
        .o_function(o_fn0), .o_user(o_user0), .o_valid(o_valid0), .i_ready(i_ready));
    hsv_prep_stream #(.CH_W(8), .IN_MODE(1), .USER_W(8)) u1 (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_user(i_user), .i_valid(i_valid),
        .o_ready(o_ready1), .o_value(o_val1), .o_delta(o_dl1), .o_dividend(o_div1),
        .o_function(o_fn1), .o_user(o_user1), .o_valid(o_valid1), .i_ready(i_ready));
    hsv_prep_stream #(.CH_W(10), .IN_MODE(1), .USER_W(8)) u2 (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_user(i_user), .i_valid(i_valid),
        .o_ready(o_ready2), .o_value(o_val2), .o_delta(o_dl2), .o_dividend(o_div2),
        .o_function(o_fn2), .o_user(o_user2), .o_valid(o_valid2), .i_ready(i_ready));

    function automatic exp_t mk(input int v, input int dl, input int dv, input int f);
        exp_t e;
        e.v = v; e.dl = dl; e.dv = dv; e.f = f;
        return e;
    endfunction

    // Reference: expand channels, pick max with red>green>blue priority on ties.
    function automatic exp_t model(input int mode, input int chw, input logic [23:0] d);
        int r, g, b, mx, mn;
        exp_t e;
        if (mode == 0) begin
            r = int'(d[4:0])   << (chw - 5);
            g = int'(d[10:5])  << (chw - 6);
            b = int'(d[15:11]) << (chw - 5);
        end else begin
            r = int'(d[7:0])   << (chw - 8);
            g = int'(d[15:8])  << (chw - 8);
            b = int'(d[23:16]) << (chw - 8);
        end
        mx = r; e.f = 1; e.dv = g - b;
        if (g > mx) begin mx = g; e.f = 2; e.dv = b - r; end
        if (b > mx) begin mx = b; e.f = 3; e.dv = r - g; end
        mn = (r < g) ? r : g;
        if (b < mn) mn = b;
        e.v  = mx;
        e.dl = mx - mn;
        if (e.dl == 0) begin e.f = 0; e.dv = 0; end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input exp_t a, input exp_t e, input int au, input int eu);
        total++;
        if (a != e || au != eu) begin
            bad++;
            $display("FAIL %s got v=%0d dl=%0d dv=%0d f=%0d u=%0d want v=%0d dl=%0d dv=%0d f=%0d u=%0d",
                     name, a.v, a.dl, a.dv, a.f, au, e.v, e.dl, e.dv, e.f, eu);
        end
    endtask

    exp_t  a0, a1, a2, p0, p1, p2;
    int    pu0, pu1, pu2;
    logic  prev_stall;
    beat_t bt;

    // Per-cycle monitor: ready rule, stall stability and in-order scoreboard.
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            a0 = mk(int'(o_val0), int'(o_dl0), int'(o_div0), int'(o_fn0));
            a1 = mk(int'(o_val1), int'(o_dl1), int'(o_div1), int'(o_fn1));
            a2 = mk(int'(o_val2), int'(o_dl2), int'(o_div2), int'(o_fn2));
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
                chk("rst_o_ready", int'({o_ready0, o_ready1, o_ready2}), 7);
            end else begin
                chk("o_ready", int'({o_ready0, o_ready1, o_ready2}),
                    ((sb.size() < 3) || i_ready) ? 7 : 0);
                if (prev_stall) begin
                    chk_beat("hold_565", a0, p0, int'(o_user0), pu0);
                    chk_beat("hold_888", a1, p1, int'(o_user1), pu1);
                    chk_beat("hold_888w10", a2, p2, int'(o_user2), pu2);
                end
                if (o_valid0 && i_ready) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_beat got=valid want=no_beat");
                    end else begin
                        bt = sb.pop_front();
                        chk_beat("beat_565", a0, model(0, 8, bt.d), int'(o_user0), int'(bt.u));
                        chk_beat("beat_888", a1, model(1, 8, bt.d), int'(o_user1), int'(bt.u));
                        chk_beat("beat_888w10", a2, model(1, 10, bt.d), int'(o_user2), int'(bt.u));
                    end
                end
                if (i_valid && o_ready0) begin
                    bt = {i_data, i_user};
                    sb.push_back(bt);
                end
                prev_stall = o_valid0 && !i_ready;
                p0 = a0; p1 = a1; p2 = a2;
                pu0 = int'(o_user0); pu1 = int'(o_user1); pu2 = int'(o_user2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_one(input logic [23:0] d, input logic [7:0] u);
        i_data = d; i_user = u; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    logic [23:0] pix [10];
    logic        acc;
    int          idx, c;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0; i_user = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'({o_valid0, o_valid1, o_valid2}), 0);
        chk("rst_out565", int'(|{o_val0, o_dl0, o_div0, o_fn0, o_user0}), 0);
        chk("rst_out888w10", int'(|{o_val2, o_dl2, o_div2, o_fn2, o_user2}), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", int'(o_valid0), 0);
        chk("post_rst_ready", int'(o_ready0), 1);

        // Hand-computed expectations
        send_one(24'h00001F, 8'h01);
        chk("lit_red_valid", int'(o_valid0), 1);
        chk_beat("lit_565_red", mk(int'(o_val0), int'(o_dl0), int'(o_div0), int'(o_fn0)),
                 mk(248, 248, 0, 1), int'(o_user0), 1);
        send_one(24'h00FFFF, 8'h02);
        chk_beat("lit_565_white", mk(int'(o_val0), int'(o_dl0), int'(o_div0), int'(o_fn0)),
                 mk(252, 4, 0, 2), int'(o_user0), 2);
        send_one(24'h000000, 8'h03);
        chk("lit_black_valid", int'(o_valid0), 1);
        chk_beat("lit_565_black", mk(int'(o_val0), int'(o_dl0), int'(o_div0), int'(o_fn0)),
                 mk(0, 0, 0, 0), int'(o_user0), 3);
        send_one(24'hFF00FF, 8'h04);
        chk_beat("lit_888_tie", mk(int'(o_val1), int'(o_dl1), int'(o_div1), int'(o_fn1)),
                 mk(255, 255, -255, 1), int'(o_user1), 4);
        chk("lit_888_tie_bits", int'($unsigned(o_div1)), 'h101);
        chk_beat("lit_565_of_ff00ff", mk(int'(o_val0), int'(o_dl0), int'(o_div0), int'(o_fn0)),
                 mk(248, 248, 28, 1), int'(o_user0), 4);
        send_one(24'h00FF40, 8'h05);
        chk_beat("lit_888_w10", mk(int'(o_val2), int'(o_dl2), int'(o_div2), int'(o_fn2)),
                 mk(1020, 1020, -256, 2), int'(o_user2), 5);
        chk("lit_888_w10_bits", int'($unsigned(o_div2)), 'h700);
        drain();

        // Ten-pixel stream with a six-cycle downstream stall
        for (int k = 0; k < 10; k++) pix[k] = 24'($urandom);
        idx = 0; c = 0;
        while (idx < 10 && c < 100) begin
            i_valid = 1'b1; i_data = pix[idx]; i_user = 8'(8'h40 + idx);
            i_ready = !(c >= 5 && c < 11);
            @(negedge clk);
            acc = o_ready0;
            @(posedge clk); #1;
            if (c == 8) begin
                chk("stall_inflight", sb.size(), 3);
                chk("stall_o_ready", int'(o_ready0), 0);
            end
            if (acc) idx++;
            c++;
        end
        chk("stream_sent", idx, 10);
        drain();

        // Random valid/ready traffic
        for (int k = 0; k < 300; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_data  = 24'($urandom);
            i_user  = 8'($urandom);
            @(posedge clk); #1;
        end
        drain();

        // Reset with three pixels in flight
        i_ready = 1'b0;
        repeat (3) begin
            i_valid = 1'b1; i_data = 24'($urandom); i_user = 8'($urandom);
            @(posedge clk); #1;
        end
        chk("pre_rst_inflight", sb.size(), 3);
        chk("pre_rst_full", int'(o_ready0), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", int'({o_valid0, o_valid1, o_valid2}), 0);
        chk("midrst_ready", int'({o_ready0, o_ready1, o_ready2}), 7);
        chk("midrst_out", int'(|{o_val0, o_dl0, o_div0, o_fn0, o_user0,
                                o_val1, o_dl1, o_div1, o_fn1, o_user1,
                                o_val2, o_dl2, o_div2, o_fn2, o_user2}), 0);
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_valid", int'(o_valid0), 0);
        chk("after_rst_ready", int'(o_ready0), 1);
        send_one(24'h00001F, 8'h77);
        chk("resume_valid", int'(o_valid0), 1);
        chk_beat("resume_565_red", mk(int'(o_val0), int'(o_dl0), int'(o_div0), int'(o_fn0)),
                 mk(248, 248, 0, 1), int'(o_user0), 'h77);
        drain();
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_valid", int'(o_valid0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
